// File: rtl/wb_if.sv
// Writeback input channels: issue-stage claims, execute results (valid/ready)
// and memory load results (valid only, never back-pressured).
interface wb_if #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      claim_en;
  logic [REG_ADDR_WIDTH-1:0] claim_addr;
  logic                      ex_valid;
  logic                      ex_ready;
  logic [REG_ADDR_WIDTH-1:0] ex_addr;
  logic [XLEN-1:0]           ex_val;
  logic                      mem_valid;
  logic [REG_ADDR_WIDTH-1:0] mem_addr;
  logic [2:0]                mem_funct3;
  logic [1:0]                mem_off;
  logic [XLEN-1:0]           mem_data;

  modport master (
    output claim_en, claim_addr,
    output ex_valid, ex_addr, ex_val,
    input  ex_ready,
    output mem_valid, mem_addr, mem_funct3, mem_off, mem_data
  );

  modport slave (
    input  claim_en, claim_addr,
    input  ex_valid, ex_addr, ex_val,
    output ex_ready,
    input  mem_valid, mem_addr, mem_funct3, mem_off, mem_data
  );
endinterface

// File: rtl/wb_unit.sv
// Register-file writeback: single write port shared by loads (highest priority)
// and execute results (one-entry hold buffer), plus a pending-load scoreboard.
module wb_unit #(
  parameter int XLEN           = 32,
  parameter int REG_CNT        = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  wb_if.slave                       bus,
  output logic [XLEN*REG_CNT-1:0]   regs,
  output logic [REG_CNT-1:0]        busy,
  output logic                      wb_done,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic                      mem_err
);
  localparam logic [REG_ADDR_WIDTH:0] CNT = (REG_ADDR_WIDTH+1)'(REG_CNT);

  logic [REG_CNT-1:0][XLEN-1:0] rf;
  logic                         hold_valid;
  logic [REG_ADDR_WIDTH-1:0]    hold_addr;
  logic [XLEN-1:0]              hold_val;

  logic                         ex_fire;
  logic                         port_use, wr_en, ld_err, ld_ok;
  logic [REG_ADDR_WIDTH-1:0]    wr_addr;
  logic [XLEN-1:0]              wr_val, ld_val;
  logic [7:0]                   ld_b;
  logic [15:0]                  ld_h;
  logic [REG_CNT-1:0]           busy_nxt;

  // Register 0 and out-of-range indices are never stored or marked busy.
  function automatic logic in_rf(input logic [REG_ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < CNT) && (a != '0);
  endfunction

  assign bus.ex_ready = !hold_valid;
  assign ex_fire      = bus.ex_valid && !hold_valid;
  assign regs         = rf;

  always_comb begin
    ld_b   = bus.mem_data[8*bus.mem_off +: 8];
    ld_h   = bus.mem_data[16*bus.mem_off[1] +: 16];
    ld_ok  = 1'b0;
    ld_val = bus.mem_data;
    unique case (bus.mem_funct3[1:0])
      2'b00: begin
        ld_ok  = 1'b1;
        ld_val = {{(XLEN-8){ld_b[7] & ~bus.mem_funct3[2]}}, ld_b};
      end
      2'b01: begin
        ld_ok  = !bus.mem_off[0];
        ld_val = {{(XLEN-16){ld_h[15] & ~bus.mem_funct3[2]}}, ld_h};
      end
      2'b10:   ld_ok = (bus.mem_off == 2'b00);
      default: ld_ok = 1'b0;
    endcase
  end

  // Port arbitration: load, then held execute entry, then incoming execute beat.
  always_comb begin
    port_use = 1'b0;
    ld_err   = 1'b0;
    wr_addr  = '0;
    wr_val   = '0;
    if (bus.mem_valid) begin
      wr_addr  = bus.mem_addr;
      wr_val   = ld_val;
      port_use = ld_ok;
      ld_err   = !ld_ok;
    end else if (hold_valid) begin
      port_use = 1'b1;
      wr_addr  = hold_addr;
      wr_val   = hold_val;
    end else if (ex_fire) begin
      port_use = 1'b1;
      wr_addr  = bus.ex_addr;
      wr_val   = bus.ex_val;
    end
  end

  assign wr_en = port_use && in_rf(wr_addr);

  // Claim is applied after clear so a same-cycle claim/clear leaves busy set.
  always_comb begin
    busy_nxt = busy;
    if (bus.mem_valid && in_rf(bus.mem_addr))
      busy_nxt[bus.mem_addr] = 1'b0;
    if (bus.claim_en && in_rf(bus.claim_addr))
      busy_nxt[bus.claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf         <= '0;
      busy       <= '0;
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_val   <= '0;
      wb_done    <= 1'b0;
      wb_addr    <= '0;
      mem_err    <= 1'b0;
    end else begin
      if (wr_en) rf[wr_addr] <= wr_val;
      busy    <= busy_nxt;
      wb_done <= port_use;
      mem_err <= ld_err;
      if (port_use) wb_addr <= wr_addr;
      if (bus.mem_valid && ex_fire) begin
        hold_valid <= 1'b1;
        hold_addr  <= bus.ex_addr;
        hold_val   <= bus.ex_val;
      end else if (!bus.mem_valid && hold_valid) begin
        hold_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: expected writes queued at drive time and
// popped when wb_done is observed.
module tb_wb_unit;
  localparam int XLEN = 32;
  localparam int RC   = 32;
  localparam int AW   = 5;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
  } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [XLEN*RC-1:0] regs;
  logic [RC-1:0]      busy;
  logic               wb_done, mem_err;
  logic [AW-1:0]      wb_addr;

  int checks = 0;
  int failures = 0;
  wb_t q[$];

  wb_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) bus ();

  wb_unit #(.XLEN(XLEN), .REG_CNT(RC), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .regs(regs), .busy(busy), .wb_done(wb_done), .wb_addr(wb_addr), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] reg_at(input int a);
    return regs[XLEN*a +: XLEN];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
    wb_t e;
    e.addr = a;
    e.val  = (a == '0) ? '0 : v;
    q.push_back(e);
  endtask

  task automatic expect_wb(input string tag);
    wb_t e;
    chk({tag, "_done"}, {31'd0, wb_done}, 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_addr"}, {27'd0, wb_addr}, {27'd0, e.addr});
      chk({tag, "_val"}, reg_at(int'(e.addr)), e.val);
    end
  endtask

  task automatic idle_in();
    bus.claim_en  = 1'b0;
    bus.ex_valid  = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [2:0] f3, input logic [1:0] off,
                      input logic [XLEN-1:0] data, input logic ok, input logic [XLEN-1:0] exp,
                      input string tag);
    bus.mem_valid  = 1'b1;
    bus.mem_addr   = a;
    bus.mem_funct3 = f3;
    bus.mem_off    = off;
    bus.mem_data   = data;
    if (ok) push(a, exp);
    tick();
    idle_in();
    chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, !ok});
    if (ok) expect_wb(tag);
    else chk({tag, "_nodone"}, {31'd0, wb_done}, 32'd0);
  endtask

  initial begin
    bus.claim_en = 1'b0; bus.claim_addr = '0;
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd5; bus.ex_val = 32'h1234_5678;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_funct3 = 3'b010;
    bus.mem_off = 2'b00; bus.mem_data = '0;

    // Reset held over two edges while an execute beat is offered
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    idle_in();
    chk("rst_regs_or", {31'd0, |regs}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);

    // Plain execute write, then a write to register 0
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd5; bus.ex_val = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    tick(); idle_in();
    expect_wb("ex5");
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd0; bus.ex_val = 32'hFFFF_FFFF;
    push(5'd0, 32'hFFFF_FFFF);
    tick(); idle_in();
    expect_wb("ex0");
    tick();
    chk("idle_no_done", {31'd0, wb_done}, 32'd0);

    // Load and execute collide: load first, execute held one cycle
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd3; bus.mem_funct3 = 3'b010;
    bus.mem_off = 2'b00; bus.mem_data = 32'h1122_3344;
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd4; bus.ex_val = 32'h0000_00AA;
    push(5'd3, 32'h1122_3344);
    push(5'd4, 32'h0000_00AA);
    tick(); idle_in();
    chk("coll_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
    chk("coll_reg4_pending", reg_at(4), 32'd0);
    expect_wb("coll_mem");
    tick();
    expect_wb("coll_ex");
    chk("coll_ex_ready_back", {31'd0, bus.ex_ready}, 32'd1);

    // Load formatting on 0x80F07F81
    load(5'd10, 3'b000, 2'd1, 32'h80F0_7F81, 1'b1, 32'h0000_007F, "lb1");
    load(5'd11, 3'b000, 2'd3, 32'h80F0_7F81, 1'b1, 32'hFFFF_FF80, "lb3");
    load(5'd12, 3'b100, 2'd2, 32'h80F0_7F81, 1'b1, 32'h0000_00F0, "lbu2");
    load(5'd13, 3'b001, 2'd2, 32'h80F0_7F81, 1'b1, 32'hFFFF_80F0, "lh2");
    load(5'd14, 3'b101, 2'd0, 32'h80F0_7F81, 1'b1, 32'h0000_7F81, "lhu0");
    load(5'd15, 3'b010, 2'd0, 32'h80F0_7F81, 1'b1, 32'h80F0_7F81, "lw0");

    // Misaligned half to a busy register: dropped, busy still cleared
    bus.claim_en = 1'b1; bus.claim_addr = 5'd7;
    tick(); idle_in();
    chk("claim7", {31'd0, busy[7]}, 32'd1);
    load(5'd7, 3'b001, 2'd1, 32'hCAFE_F00D, 1'b0, '0, "lh_mis");
    chk("mis_reg7", reg_at(7), 32'd0);
    chk("mis_busy7", {31'd0, busy[7]}, 32'd0);
    tick();
    chk("mis_err_pulse", {31'd0, mem_err}, 32'd0);
    load(5'd8, 3'b011, 2'd0, 32'hCAFE_F00D, 1'b0, '0, "ill_size");
    load(5'd8, 3'b010, 2'd2, 32'hCAFE_F00D, 1'b0, '0, "lw_mis");
    chk("ill_reg8", reg_at(8), 32'd0);

    // Scoreboard: claim, claim+clear same cycle, clear alone, claim to r0
    bus.claim_en = 1'b1; bus.claim_addr = 5'd9;
    tick(); idle_in();
    chk("sb_claim9", busy, 32'h0000_0200);
    bus.claim_en = 1'b1; bus.claim_addr = 5'd9;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_funct3 = 3'b010;
    bus.mem_off = 2'd0; bus.mem_data = 32'h0000_0055;
    push(5'd9, 32'h0000_0055);
    tick(); idle_in();
    chk("sb_both9", busy, 32'h0000_0200);
    expect_wb("sb_both_wb");
    load(5'd9, 3'b010, 2'd0, 32'h0000_0066, 1'b1, 32'h0000_0066, "sb_clr9");
    chk("sb_clr9_busy", busy, 32'd0);
    bus.claim_en = 1'b1; bus.claim_addr = 5'd0;
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd9; bus.ex_val = 32'h0000_0077;
    push(5'd9, 32'h0000_0077);
    tick(); idle_in();
    chk("sb_claim0", busy, 32'd0);
    expect_wb("ex9_nobusy");

    // Reset discards a held execute entry
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd20; bus.mem_funct3 = 3'b010;
    bus.mem_off = 2'd0; bus.mem_data = 32'h0BAD_0BAD;
    bus.ex_valid = 1'b1; bus.ex_addr = 5'd21; bus.ex_val = 32'h0000_1111;
    tick(); idle_in();
    chk("hold_before_rst", {31'd0, bus.ex_ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_regs_or", {31'd0, |regs}, 32'd0);
    chk("rst2_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst2_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    chk("sb_leftover", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
# wb_unit

Register-file writeback stage for the bf8b core, generalised in datapath width and register count, with two result channels: execute and memory. It merges ALU results and load data into the architectural register file through a single write port. It also aligns and sign-extends sub-word loads at any byte offset and keeps a per-register pending-load scoreboard for issue-stage hazard checks. It sits after execute and memory access and drives the packed register file back to decode/execute.

## Interface
- XLEN, 32, register and datapath width in bits (multiple of 8, ≥ 32)
- REG_CNT, 32, number of architectural registers
- REG_ADDR_WIDTH, 5, register index width (2^REG_ADDR_WIDTH ≥ REG_CNT)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- claim_en  in  1  issue stage reserves a destination for an outstanding load
- claim_addr  in  REG_ADDR_WIDTH  register to mark busy
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted when ex_valid && ex_ready
- ex_addr  in  REG_ADDR_WIDTH  execute destination
- ex_val  in  XLEN  full-width execute result, written as-is
- mem_valid  in  1  load result present; never back-pressured
- mem_addr  in  REG_ADDR_WIDTH  load destination
- mem_funct3  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2]=1 zero-extend
- mem_off  in  2  byte offset of load address within the word
- mem_data  in  XLEN  aligned word read from memory
- regs  out  XLEN*REG_CNT  packed register file; register i at [XLEN*i +: XLEN]
- busy  out  REG_CNT  pending-load scoreboard; bit 0 always 0
- wb_done  out  1  one-cycle pulse: a register write happened on the previous edge
- wb_addr  out  REG_ADDR_WIDTH  destination of that write
- mem_err  out  1  one-cycle pulse: misaligned or illegal load was dropped

## Operation
- Single write port. Priority per cycle: mem_valid first, then the held execute entry, then the incoming execute beat.
- Hold buffer: one entry (hold_valid, hold_addr, hold_val).
  - ex_ready = !hold_valid (combinational).
  - An accepted execute beat is written the same edge if mem_valid=0 and hold_valid=0. Otherwise it is captured into the hold buffer.
  - When mem_valid=0 and hold_valid=1, the held entry is written and hold_valid clears. ex_ready is 0 in that cycle, so no new beat is accepted.
- Load formatting, with b = mem_data[8*mem_off +: 8] and h = mem_data[16*mem_off[1] +: 16]:
  - Byte: b, extended by b[7] & ~funct3[2].
  - Half: requires mem_off[0]=0; h, extended by h[15] & ~funct3[2].
  - Word: requires mem_off=00; mem_data unchanged.
  - Misalignment or size 11: no register write, mem_err pulses, busy[mem_addr] still clears.
- Register 0 reads as 0 always. Writes to address 0 are discarded but still consume the port, pulse wb_done, and set wb_addr=0. Claims to address 0 are ignored.
- Scoreboard:
  - claim_en sets busy[claim_addr].
  - Any mem_valid beat clears busy[mem_addr].
  - Same register claimed and cleared in the same cycle: busy ends up set.
  - Execute writes never change busy.
  - The block does not stall on busy; issue must not send an execute write to a busy register.
- Addresses ≥ REG_CNT: write and claim are ignored; wb_done still pulses.

## Timing
- Reset (rst_n=0 at an edge):
  - All regs 0, busy 0, hold_valid 0, wb_done 0, wb_addr 0, mem_err 0.
  - ex_ready reads 1 from the first cycle after reset.
  - Reset overrides every simultaneous write, claim, and held entry; the held entry is lost.
- Write latency: a result written at edge N is visible on regs after edge N. wb_done/wb_addr are valid in the cycle following edge N.
- Execute beat colliding with mem_valid: written at the first edge with mem_valid=0, i.e. one cycle later if mem is idle next cycle.
- Sustained mem_valid starves the hold buffer and ex_ready stays 0. Memory must leave at least one idle cycle per execute result to avoid starvation.
- mem_err pulses in the cycle after the offending beat's edge.

## Test plan
- Reset: hold rst_n=0 over 2 edges with ex_valid=1 → regs all 0, busy=0, wb_done=0, ex_ready=1 after release.
- Execute write: ex_valid=1, ex_addr=5, ex_val=0xDEADBEEF → reg5=0xDEADBEEF after edge, wb_done=1 with wb_addr=5 next cycle; same to addr 0 → reg0 stays 0.
- Collision: mem_valid (addr 3, word 0x11223344) and ex_valid (addr 4, 0xAA) in the same cycle:
  - reg3 is written first, the execute beat is held, and ex_ready=0 the next cycle.
  - reg4=0xAA is written one edge later.
- Load formatting with mem_data=0x80F07F81:
  - lb off=1 → 0x0000007F; lb off=3 → 0xFFFFFF80.
  - lbu off=2 → 0x000000F0; lh off=2 → 0xFFFF80F0.
- Misaligned: lh off=1 to addr 7 with busy[7]=1 → reg7 unchanged, mem_err pulses, busy[7]=0.
- Scoreboard: claim addr 9 → busy[9]=1. Claim 9 and mem_valid addr 9 in the same cycle → busy[9] stays 1. Mem_valid addr 9 alone → 0.
